// File: rtl/aer_event_capture.sv
// aer_event_capture: AER four-phase receiver that timestamps events into a FWFT FIFO.
// Define AER_CAPTURE_DROP_EN to drop (and flag) events arriving while the FIFO is full.
module aer_event_capture #(
  parameter int M     = 8,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [M-1:0]             AER_ADDR,
  input  logic                     AER_REQ,
  output logic                     AER_ACK,
  input  logic                     RD_EN,
  output logic [TS_W+M-1:0]        RD_DATA,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  input  logic                     CLR_OVF
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACK_HI, WAIT_LOW} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic req_s, hold, accept, wr, pop, drop;
  logic [TS_W-1:0] ts;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TS_W+M-1:0] mem [DEPTH];
  assign req_s  = sync[1];
  assign accept = state == IDLE && req_s;
  assign wr     = accept && !FULL;
  assign pop    = RD_EN && !EMPTY;
`ifdef AER_CAPTURE_DROP_EN
  assign drop   = accept && FULL;
`else
  assign drop   = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      hold  <= 1'b0;
    end else begin
      state <= state_nx;
      hold  <= state == ACK_HI && !hold;
    end
  // hold marks the second ACK_HI cycle so ACK stays high exactly two cycles
  always_comb
    state_nx = state == IDLE   ? ((wr || drop) ? ACK_HI : IDLE) :
               state == ACK_HI ? (hold ? WAIT_LOW : ACK_HI) :
               (req_s ? WAIT_LOW : IDLE);
  always_comb AER_ACK = state == ACK_HI;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync     <= '0;
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      sync     <= {sync[0], AER_REQ};
      ts       <= ts + 1'b1;
      wr_ptr   <= wr_ptr + AW'(wr);
      rd_ptr   <= rd_ptr + AW'(pop);
      COUNT    <= COUNT + (AW+1)'(wr) - (AW+1)'(pop);
      OVERFLOW <= drop ? 1'b1 : CLR_OVF ? 1'b0 : OVERFLOW;
    end
  always_ff @(posedge CLK)
    if (wr) mem[wr_ptr] <= {ts, AER_ADDR};
  assign EMPTY   = COUNT == '0;
  assign FULL    = COUNT == (AW+1)'(DEPTH);
  assign RD_DATA = EMPTY ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_aer_event_capture.sv
// tb_aer_event_capture: directed checks of handshake, timestamps, FIFO order and limits.
module tb_aer_event_capture;
  logic CLK = 0, RST = 1, AER_REQ = 0, RD_EN = 0, CLR_OVF = 0;
  logic [7:0] AER_ADDR = '0;
  logic AER_ACK, EMPTY, FULL, OVERFLOW;
  logic [11:0] RD_DATA;
  logic [4:0] COUNT;
  int checks = 0, failures = 0, ecount = 0;
  logic [11:0] exp_q[$];

  aer_event_capture #(.M(8), .DEPTH(16), .TS_W(4)) dut (
    .CLK(CLK), .RST(RST), .AER_ADDR(AER_ADDR), .AER_REQ(AER_REQ), .AER_ACK(AER_ACK),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF));

  always #5 CLK = ~CLK;
  always @(posedge CLK) ecount <= RST ? 0 : ecount + 1;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    while (!AER_ACK && k < 20) begin
      tick();
      k++;
    end
  endtask

  task automatic finish_hs(input string tag);
    tick();
    check({tag, "_ack_hold"}, AER_ACK, 1);
    tick();
    check({tag, "_ack_low"}, AER_ACK, 0);
    AER_REQ = 0;
    repeat (3) tick();
  endtask

  task automatic send_event(input logic [7:0] a, input string tag);
    int k;
    AER_ADDR = a;
    AER_REQ = 1;
    wait_ack(k);
    check({tag, "_lat"}, k, 3);
    exp_q.push_back({4'(ecount - 1), a});
    finish_hs(tag);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check({tag, "_order"}, RD_DATA, exp_q.pop_front());
      RD_EN = 1;
      tick();
      RD_EN = 0;
    end
    check({tag, "_empty"}, EMPTY, 1);
    check({tag, "_count0"}, COUNT, 0);
  endtask

  initial begin
    int k;
    repeat (3) tick();
    check("rst_ack", AER_ACK, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_count", COUNT, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_rdata", RD_DATA, 0);
    RST = 0;
    repeat (5) tick();
    RD_EN = 1;
    tick();
    RD_EN = 0;
    check("rd_empty_count", COUNT, 0);
    check("rd_empty_empty", EMPTY, 1);

    AER_ADDR = 8'h5A;
    AER_REQ = 1;
    tick();
    tick();
    check("single_ack_pre", AER_ACK, 0);
    check("single_empty_pre", EMPTY, 1);
    tick();
    check("single_ack_rise", AER_ACK, 1);
    check("single_empty_fall", EMPTY, 0);
    check("single_data", RD_DATA, {4'(ecount - 1), 8'h5A});
    exp_q.push_back({4'(ecount - 1), 8'h5A});
    finish_hs("single");
    drain("single");

    send_event(8'h11, "wrapA");
    repeat (12) tick();
    send_event(8'h22, "wrapB");
    drain("wrap");

    send_event(8'h33, "pre_sim");
    AER_ADDR = 8'h44;
    AER_REQ = 1;
    tick();
    tick();
    RD_EN = 1;
    tick();
    RD_EN = 0;
    check("sim_ack", AER_ACK, 1);
    check("sim_count", COUNT, 1);
    void'(exp_q.pop_front());
    exp_q.push_back({4'(ecount - 1), 8'h44});
    check("sim_data", RD_DATA, exp_q[0]);
    finish_hs("sim");
    drain("sim");

    for (int i = 0; i < 16; i++) send_event(8'(i * 7 + 1), "fill");
    check("fill_full", FULL, 1);
    check("fill_count", COUNT, 16);

    AER_ADDR = 8'hEE;
    AER_REQ = 1;
`ifdef AER_CAPTURE_DROP_EN
    wait_ack(k);
    check("drop_lat", k, 3);
    check("drop_ovf", OVERFLOW, 1);
    check("drop_count", COUNT, 16);
    finish_hs("drop");
    CLR_OVF = 1;
    tick();
    CLR_OVF = 0;
    check("drop_clr", OVERFLOW, 0);
`else
    k = 0;
    repeat (8) begin
      tick();
      if (AER_ACK) k++;
    end
    check("bp_ack_blocked", k, 0);
    check("bp_ovf", OVERFLOW, 0);
    check("bp_head", RD_DATA, exp_q.pop_front());
    RD_EN = 1;
    tick();
    RD_EN = 0;
    check("bp_full_fall", FULL, 0);
    check("bp_ack_still0", AER_ACK, 0);
    tick();
    check("bp_ack_rise", AER_ACK, 1);
    check("bp_count", COUNT, 16);
    exp_q.push_back({4'(ecount - 1), 8'hEE});
    finish_hs("bp");
`endif
    drain("fill");
    check("drain_full", FULL, 0);

    AER_ADDR = 8'h66;
    AER_REQ = 1;
    wait_ack(k);
    check("rst_hs_ack", AER_ACK, 1);
    #2 RST = 1;
    #1;
    check("rst_hs_ack_drop", AER_ACK, 0);
    check("rst_hs_empty", EMPTY, 1);
    check("rst_hs_count", COUNT, 0);
    AER_REQ = 0;
    tick();
    tick();
    RST = 0;
    repeat (2) tick();
    send_event(8'h77, "after_rst");
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
